// File: rtl/rgb_line_reader.sv
// rgb_line_reader: sweeps one line out of the line buffer RAM into a 2-deep valid/ready pixel stream
module rgb_line_reader #(
   parameter int ADDR_W   = 13,
   parameter int DATA_W   = 16,
   parameter int LINE_LEN = 1280
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              BUF_FILLED,
   output logic [ADDR_W-1:0] RD_ADDR,
   input  logic [DATA_W-1:0] HDMI_DTA,
   output logic [DATA_W-1:0] PIX_DTA,
   output logic              PIX_VALID,
   input  logic              PIX_READY,
   output logic              PIX_LAST,
   output logic              LINE_DONE,
   output logic              BUSY,
   output logic              OVERRUN
);
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LINE_LEN - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] addr_n;
   logic              buf_q, armed, trig, pop, push, iss, iss_last, infl_last;
   logic              e0_last, e1_last;
   logic [DATA_W-1:0] e0, e1;
   logic [1:0]        fcnt;

   if (LINE_LEN < 2 || LINE_LEN - 1 >= 2 ** ADDR_W) begin : g_bad_len
      $error("LINE_LEN must be >= 2 and LINE_LEN-1 must fit in ADDR_W bits");
   end

   // armed masks the first cycle out of reset so a level already high is not a trigger
   assign trig      = BUF_FILLED & ~buf_q & armed;
   assign PIX_VALID = fcnt != 2'd0;
   assign pop       = PIX_VALID & PIX_READY;
   assign PIX_DTA   = e0;
   assign PIX_LAST  = PIX_VALID & e0_last;
   assign BUSY      = state != IDLE;

   // next state and read issue; a read is issued only if its data is sure to find a FIFO slot
   always_comb begin
      state_n  = state;
      addr_n   = RD_ADDR;
      iss      = 1'b0;
      iss_last = 1'b0;
      case (state)
         IDLE: if (trig) begin
            iss     = 1'b1;
            addr_n  = ADDR_W'(1);
            state_n = FETCH;
         end
         FETCH: if ({1'b0, fcnt} + {2'b0, push} - {2'b0, pop} < 3'd2) begin
            iss      = 1'b1;
            iss_last = RD_ADDR == LAST_A;
            state_n  = iss_last ? DRAIN : FETCH;
            addr_n   = iss_last ? RD_ADDR : RD_ADDR + ADDR_W'(1);
         end
         DRAIN: if (pop && e0_last) begin
            state_n = IDLE;
            addr_n  = '0;
         end
         default: state_n = IDLE;
      endcase
   end

   // state, address, in-flight tag and the two FIFO entries (e0 is the head)
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         RD_ADDR   <= '0;
         buf_q     <= 1'b0;
         armed     <= 1'b0;
         push      <= 1'b0;
         infl_last <= 1'b0;
         fcnt      <= 2'd0;
         e0        <= '0;
         e1        <= '0;
         e0_last   <= 1'b0;
         e1_last   <= 1'b0;
         LINE_DONE <= 1'b0;
         OVERRUN   <= 1'b0;
      end else begin
         state     <= state_n;
         RD_ADDR   <= addr_n;
         buf_q     <= BUF_FILLED;
         armed     <= 1'b1;
         push      <= iss;
         infl_last <= iss_last;
         fcnt      <= fcnt + {1'b0, push} - {1'b0, pop};
         if (pop && fcnt == 2'd2) begin
            e0      <= e1;
            e0_last <= e1_last;
         end else if (push && fcnt == {1'b0, pop}) begin
            e0      <= HDMI_DTA;
            e0_last <= infl_last;
         end
         if (push) begin
            e1      <= HDMI_DTA;
            e1_last <= infl_last;
         end
         LINE_DONE <= state == DRAIN && pop && e0_last;
         OVERRUN   <= OVERRUN | (trig & BUSY);
      end
   end

   // a push into a full FIFO with no pop means the room check above is broken
   always_ff @(posedge i_clk) begin
      if (!i_rst) assert (!(push && !pop && fcnt == 2'd2));
   end
endmodule

// File: tb/tb_rgb_line_reader.sv
// tb_rgb_line_reader: directed checks of line sweep, backpressure, overrun and reset abort
module tb_rgb_line_reader;
   localparam int AW  = 13;
   localparam int DW  = 16;
   localparam int LEN = 1280;

   logic          i_clk = 1'b0, i_rst = 1'b1, BUF_FILLED = 1'b0, PIX_READY = 1'b0;
   logic [AW-1:0] RD_ADDR;
   logic [DW-1:0] HDMI_DTA, PIX_DTA, hold_d;
   logic          PIX_VALID, PIX_LAST, LINE_DONE, BUSY, OVERRUN, hold_l;
   int            n_chk = 0, n_pass = 0, cyc_n = 0, exp_idx = 0, first_cyc = -1, done_cyc = -1;
   int            done_cnt = 0, ovr_at = -1, bf_hold = 0, t0, t1, d;
   bit            rmode = 1'b0, contig = 1'b0, hold_v = 1'b0;

   rgb_line_reader #(.ADDR_W(AW), .DATA_W(DW), .LINE_LEN(LEN)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .BUF_FILLED(BUF_FILLED), .RD_ADDR(RD_ADDR),
      .HDMI_DTA(HDMI_DTA), .PIX_DTA(PIX_DTA), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
      .PIX_LAST(PIX_LAST), .LINE_DONE(LINE_DONE), .BUSY(BUSY), .OVERRUN(OVERRUN)
   );

   always #5 i_clk = ~i_clk;

   // line buffer RAM with one cycle of read latency, D[a] = a
   always @(posedge i_clk) HDMI_DTA <= DW'(RD_ADDR);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic sample();
      if (hold_v) begin
         chk("hold_valid", PIX_VALID, 1);
         chk("hold_data", PIX_DTA, hold_d);
         chk("hold_last", PIX_LAST, hold_l);
      end
      if (PIX_VALID && PIX_READY) begin
         if (exp_idx == 0) first_cyc = cyc_n;
         if (contig) chk("gapless", cyc_n, first_cyc + exp_idx);
         chk("pix_data", PIX_DTA, exp_idx);
         chk("pix_last", PIX_LAST, exp_idx == LEN - 1);
         exp_idx++;
      end
      if (LINE_DONE) begin
         done_cnt++;
         done_cyc = cyc_n;
      end
      hold_v = PIX_VALID && !PIX_READY;
      hold_d = PIX_DTA;
      hold_l = PIX_LAST;
   endtask

   task automatic cyc();
      @(negedge i_clk);
      sample();
      @(posedge i_clk);
      #1;
      cyc_n++;
      if (rmode) PIX_READY = 1'($urandom_range(0, 1));
      if (bf_hold > 0) begin
         bf_hold--;
         if (bf_hold == 0) BUF_FILLED = 1'b0;
      end
      if (ovr_at >= 0 && exp_idx == ovr_at) begin
         BUF_FILLED = 1'b1;
         bf_hold    = 3;
         ovr_at     = -1;
      end
   endtask

   task automatic trig(input int hold, output int t);
      t          = cyc_n;
      BUF_FILLED = 1'b1;
      bf_hold    = hold;
      exp_idx    = 0;
      first_cyc  = -1;
      hold_v     = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n  = 0;
      int d0 = done_cnt;
      while (done_cnt == d0 && n < budget) begin
         cyc();
         n++;
      end
      chk("line_done_seen", done_cnt - d0, 1);
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      cyc();
      cyc();
      i_rst    = 1'b0;
      exp_idx  = 0;
      done_cnt = 0;
      hold_v   = 1'b0;
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_addr"}, RD_ADDR, 0);
      chk({p, "_valid"}, PIX_VALID, 0);
      chk({p, "_last"}, PIX_LAST, 0);
      chk({p, "_done"}, LINE_DONE, 0);
      chk({p, "_busy"}, BUSY, 0);
      chk({p, "_overrun"}, OVERRUN, 0);
      chk({p, "_data"}, PIX_DTA, 0);
   endtask

   // directed sequence of line reads
   initial begin
      @(posedge i_clk);
      #1;
      BUF_FILLED = 1'b1;
      do_reset();
      chk_reset("rst");
      cyc();
      cyc();
      cyc();
      chk("no_trig_after_rst", BUSY, 0);
      BUF_FILLED = 1'b0;
      cyc();
      cyc();

      PIX_READY = 1'b1;
      contig    = 1'b1;
      trig(3, t0);
      cyc();
      chk("t1_busy", BUSY, 1);
      wait_done(3000);
      chk("t1_first_cyc", first_cyc, t0 + 2);
      chk("t1_done_cyc", done_cyc, t0 + 1282);
      chk("t1_beats", exp_idx, LEN);
      chk("t1_busy_end", BUSY, 0);
      chk("t1_done_pulse", LINE_DONE, 0);
      chk("t1_overrun", OVERRUN, 0);

      contig = 1'b0;
      rmode  = 1'b1;
      trig(3, t0);
      wait_done(8000);
      chk("t2_beats", exp_idx, LEN);
      rmode     = 1'b0;
      PIX_READY = 1'b0;
      cyc();

      contig = 1'b1;
      trig(3, t0);
      for (int n = 0; n < 10 && !PIX_VALID; n++) cyc();
      chk("t3_valid", PIX_VALID, 1);
      for (int n = 0; n < 20; n++) cyc();
      chk("t3_reads", RD_ADDR, 2);
      chk("t3_data", PIX_DTA, 0);
      chk("t3_none_taken", exp_idx, 0);
      PIX_READY = 1'b1;
      wait_done(3000);
      chk("t3_beats", exp_idx, LEN);

      contig = 1'b0;
      d      = done_cnt;
      ovr_at = 100;
      trig(3, t0);
      cyc();
      chk("t4_overrun_early", OVERRUN, 0);
      wait_done(3000);
      chk("t4_beats", exp_idx, LEN);
      for (int n = 0; n < 20; n++) cyc();
      chk("t4_one_done", done_cnt - d, 1);
      chk("t4_busy", BUSY, 0);
      chk("t4_overrun", OVERRUN, 1);

      do_reset();
      chk("t5_overrun_cleared", OVERRUN, 0);
      cyc();
      cyc();
      contig = 1'b1;
      d      = done_cnt;
      trig(500, t0);
      wait_done(3000);
      chk("t5_done_cyc", done_cyc, t0 + 1282);
      for (int n = 0; n < 30; n++) cyc();
      chk("t5_one_line", done_cnt - d, 1);
      chk("t5_busy", BUSY, 0);
      trig(3, t0);
      for (int n = 0; n < 1282; n++) cyc();
      chk("t5_ld_now", LINE_DONE, 1);
      trig(3, t1);
      cyc();
      chk("t5_restart_busy", BUSY, 1);
      wait_done(3000);
      chk("t5_first_cyc", first_cyc, t1 + 2);
      chk("t5_done_cyc2", done_cyc, t1 + 1282);
      chk("t5_beats", exp_idx, LEN);
      chk("t5_overrun", OVERRUN, 0);

      contig = 1'b0;
      trig(3, t0);
      for (int n = 0; n < 2000 && exp_idx < 600; n++) cyc();
      chk("t6_reached_600", exp_idx, 600);
      d     = done_cnt;
      i_rst = 1'b1;
      cyc();
      i_rst = 1'b0;
      chk_reset("t6_rst");
      for (int n = 0; n < 5; n++) cyc();
      chk("t6_no_done", done_cnt - d, 0);
      chk("t6_idle_addr", RD_ADDR, 0);
      chk("t6_idle_valid", PIX_VALID, 0);
      contig = 1'b1;
      trig(3, t0);
      wait_done(3000);
      chk("t6_first_cyc", first_cyc, t0 + 2);
      chk("t6_beats", exp_idx, LEN);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
